fofir_tap_scheduler: RTL and testbench

Sequences the per-tap weight selection of one FoFIR PE. It drives the current_tap select of the weight/BPR/ETC multiplexer and holds each tap for its ETC (essential term count) cycles, so the bit-serial multiplier sees every non-zero term of each weight. It can optionally skip zero-ETC taps. One "pass" covers all nb_weights taps once and ends with a done pulse to the PE controller.

---
 rtl/fofir_pkg.sv | 24 ++
 rtl/fofir_next_tap_finder.sv | 43 ++++
 rtl/fofir_tap_scheduler.sv | 153 +++++++++++++++
 tb/tb_fofir_tap_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fofir_pkg.sv
`default_nettype none
// ============================================================================
// fofir_pkg : shared FoFIR types, tap-select width and ETC field helpers
// Revision  : 1.0
// ============================================================================
package fofir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_t;

    function automatic int tap_sel_width(input int nb_weights);
        return (nb_weights > 8) ? 4 : 3;
    endfunction

    // Bit offset of tap `tap` inside a packed ETC bus (tap 0 at the LSBs).
    function automatic int etc_lsb(input int tap, input int etc_width);
        return tap * etc_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fofir_next_tap_finder.sv
`default_nettype none
// ============================================================================
// fofir_next_tap_finder : lowest eligible tap above current_tap (or from -1)
// Revision              : 1.0
// ============================================================================
module fofir_next_tap_finder
    import fofir_pkg::*;
#(
    parameter int NB_WEIGHTS = 5,
    parameter int ETC_WIDTH  = 4,
    parameter int TAP_WIDTH  = tap_sel_width(NB_WEIGHTS)
) (
    input  logic [ETC_WIDTH*NB_WEIGHTS-1:0] etcs,
    input  logic                            skip_zero,
    input  logic                            from_start,
    input  logic [TAP_WIDTH-1:0]            current_tap,
    output logic [TAP_WIDTH-1:0]            next_tap,
    output logic                            next_found
);

    logic [NB_WEIGHTS-1:0] w_eligible;

    generate
        for (genvar i = 0; i < NB_WEIGHTS; i++) begin : g_eligible
            assign w_eligible[i] = !skip_zero ||
                                   (etcs[etc_lsb(i, ETC_WIDTH) +: ETC_WIDTH] != '0);
        end
    endgenerate

    // Scan downward so the lowest qualifying index is the one that sticks.
    always_comb begin
        next_tap   = '0;
        next_found = 1'b0;
        for (int i = NB_WEIGHTS - 1; i >= 0; i--) begin
            if (w_eligible[i] && (from_start || (TAP_WIDTH'(i) > current_tap))) begin
                next_tap   = TAP_WIDTH'(i);
                next_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fofir_tap_scheduler.sv
`default_nettype none
// ============================================================================
// fofir_tap_scheduler : holds each FoFIR tap for its essential-term count
// Revision            : 1.0
// ============================================================================
module fofir_tap_scheduler
    import fofir_pkg::*;
#(
    parameter int NB_WEIGHTS = 5,
    parameter int ETC_WIDTH  = 4,
    parameter int TAP_WIDTH  = tap_sel_width(NB_WEIGHTS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            cfg_skip_zero,
    input  logic [ETC_WIDTH*NB_WEIGHTS-1:0] ETCs,
    input  logic                            stall,
    output logic                            busy,
    output logic                            tap_valid,
    output logic [TAP_WIDTH-1:0]            current_tap,
    output logic [ETC_WIDTH-1:0]            term_idx,
    output logic                            tap_last,
    output logic                            pass_done
);

    localparam int TAP_SLOTS = 2 ** TAP_WIDTH;

    fsm_state_t                      r_state, w_state_next;
    logic [ETC_WIDTH*NB_WEIGHTS-1:0] r_etc_snap;
    logic                            r_skip_snap;
    logic [TAP_WIDTH-1:0]            r_tap, w_tap_next;
    logic [ETC_WIDTH-1:0]            r_term, w_term_next;
    logic                            w_load;

    logic [ETC_WIDTH-1:0]            w_etc_table [TAP_SLOTS];
    logic [ETC_WIDTH-1:0]            w_cur_etc;
    logic [ETC_WIDTH-1:0]            w_last_idx;
    logic                            w_term_last;

    logic                            w_in_idle;
    logic [ETC_WIDTH*NB_WEIGHTS-1:0] w_find_etcs;
    logic                            w_find_skip;
    logic [TAP_WIDTH-1:0]            w_next_tap;
    logic                            w_next_found;

    // Table padded to the full select range so indexing never leaves it.
    generate
        for (genvar i = 0; i < TAP_SLOTS; i++) begin : g_etc_table
            if (i < NB_WEIGHTS) begin : g_used
                assign w_etc_table[i] = r_etc_snap[etc_lsb(i, ETC_WIDTH) +: ETC_WIDTH];
            end else begin : g_unused
                assign w_etc_table[i] = '0;
            end
        end
    endgenerate

    assign w_cur_etc   = w_etc_table[r_tap];
    // A zero-ETC tap still issues one term when it is not skipped.
    assign w_last_idx  = (w_cur_etc == '0) ? '0 : (w_cur_etc - 1'b1);
    assign w_term_last = (r_term == w_last_idx);

    // In IDLE the search runs on the live inputs to find the first tap.
    assign w_in_idle   = (r_state == ST_IDLE);
    assign w_find_etcs = w_in_idle ? ETCs : r_etc_snap;
    assign w_find_skip = w_in_idle ? cfg_skip_zero : r_skip_snap;

    fofir_next_tap_finder #(
        .NB_WEIGHTS (NB_WEIGHTS),
        .ETC_WIDTH  (ETC_WIDTH),
        .TAP_WIDTH  (TAP_WIDTH)
    ) u_finder (
        .etcs        (w_find_etcs),
        .skip_zero   (w_find_skip),
        .from_start  (w_in_idle),
        .current_tap (r_tap),
        .next_tap    (w_next_tap),
        .next_found  (w_next_found)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_etc_snap  <= '0;
            r_skip_snap <= 1'b0;
            r_tap       <= '0;
            r_term      <= '0;
        end else begin
            r_state <= w_state_next;
            r_tap   <= w_tap_next;
            r_term  <= w_term_next;
            if (w_load) begin
                r_etc_snap  <= ETCs;
                r_skip_snap <= cfg_skip_zero;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tap_next   = r_tap;
        w_term_next  = r_term;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_term_next = '0;
                    if (w_next_found) begin
                        w_state_next = ST_RUN;
                        w_tap_next   = w_next_tap;
                    end else begin
                        w_state_next = ST_DONE;
                        w_tap_next   = '0;
                    end
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (!w_term_last) begin
                        w_term_next = r_term + 1'b1;
                    end else if (w_next_found) begin
                        w_tap_next  = w_next_tap;
                        w_term_next = '0;
                    end else begin
                        w_state_next = ST_DONE;
                        w_tap_next   = '0;
                        w_term_next  = '0;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
                w_tap_next   = '0;
                w_term_next  = '0;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tap_next   = '0;
                w_term_next  = '0;
            end
        endcase
    end

    assign busy        = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign tap_valid   = (r_state == ST_RUN) && !stall;
    assign tap_last    = tap_valid && w_term_last;
    assign pass_done   = (r_state == ST_DONE);
    assign current_tap = r_tap;
    assign term_idx    = r_term;

endmodule
`default_nettype wire

// File: tb/tb_fofir_tap_scheduler.sv
`default_nettype none
// ============================================================================
// tb_fofir_tap_scheduler : directed + random passes against a term-list model
// Revision               : 1.0
// ============================================================================
module tb_fofir_tap_scheduler;

    localparam int NB = 5;
    localparam int EW = 4;
    localparam int TW = 3;

    typedef struct {
        int tap;
        int term;
        bit last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            cfg_skip_zero;
    logic [EW*NB-1:0] etcs;
    logic            stall;
    logic            busy;
    logic            tap_valid;
    logic [TW-1:0]   current_tap;
    logic [EW-1:0]   term_idx;
    logic            tap_last;
    logic            pass_done;

    int checks   = 0;
    int failures = 0;
    int cur_etc [NB];

    always #5 clk = ~clk;

    fofir_tap_scheduler #(
        .NB_WEIGHTS (NB),
        .ETC_WIDTH  (EW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_skip_zero (cfg_skip_zero),
        .ETCs          (etcs),
        .stall         (stall),
        .busy          (busy),
        .tap_valid     (tap_valid),
        .current_tap   (current_tap),
        .term_idx      (term_idx),
        .tap_last      (tap_last),
        .pass_done     (pass_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [EW*NB-1:0] pack_etc();
        logic [EW*NB-1:0] v;
        for (int i = 0; i < NB; i++) v[i*EW +: EW] = cur_etc[i][EW-1:0];
        return v;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, tap_valid, 0);
        check({tag, "_done"}, pass_done, 0);
        check({tag, "_tap"}, current_tap, 0);
        check({tag, "_term"}, term_idx, 0);
        check({tag, "_last"}, tap_last, 0);
    endtask

    // Model: a pass is the ordered list of (tap, term) beats derived from the
    // ETC list; stalls only delay beats, and done follows the last beat.
    task automatic run_pass(input bit skip, input int stall_pct, input bit scramble);
        beat_t q[$];
        beat_t b;
        int    n;
        int    cycles;
        bit    done_seen;
        q = {};
        for (int i = 0; i < NB; i++) begin
            n = skip ? cur_etc[i] : ((cur_etc[i] == 0) ? 1 : cur_etc[i]);
            for (int k = 0; k < n; k++) begin
                b.tap = i; b.term = k; b.last = (k == n - 1);
                q.push_back(b);
            end
        end
        etcs = pack_etc();
        cfg_skip_zero = skip;
        stall = 1'b0;
        start = 1'b1;
        #1;
        check("start_cycle_busy", busy, 0);
        check("start_cycle_done", pass_done, 0);
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 0;
        done_seen = 1'b0;
        while (!done_seen && cycles < 400) begin
            cycles++;
            if (q.size() > 0) begin
                stall = ($urandom_range(99) < stall_pct);
                start = ($urandom_range(9) == 0);
                if (scramble) begin
                    etcs = (EW*NB)'($urandom);
                    cfg_skip_zero = $urandom_range(1);
                end
                #1;
                check("run_busy", busy, 1);
                check("run_done", pass_done, 0);
                if (stall) begin
                    check("stall_valid", tap_valid, 0);
                    check("stall_last", tap_last, 0);
                    check("stall_tap", current_tap, q[0].tap);
                    check("stall_term", term_idx, q[0].term);
                end else begin
                    check("beat_valid", tap_valid, 1);
                    check("beat_tap", current_tap, q[0].tap);
                    check("beat_term", term_idx, q[0].term);
                    check("beat_last", tap_last, q[0].last);
                    void'(q.pop_front());
                end
            end else begin
                stall = $urandom_range(1);
                start = 1'b0;
                #1;
                check("done_pulse", pass_done, 1);
                check("done_busy", busy, 1);
                check("done_valid", tap_valid, 0);
                check("done_tap", current_tap, 0);
                check("done_term", term_idx, 0);
                done_seen = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done_seen) check("pass_timeout", 0, 1);
        stall = 1'b0;
        start = 1'b0;
        check_idle("after_pass");
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cfg_skip_zero = 1'b0;
        etcs = '0;
        stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        cur_etc = '{1, 1, 1, 1, 1};
        run_pass(1'b0, 0, 1'b0);
        cur_etc = '{0, 2, 0, 3, 1};
        run_pass(1'b1, 0, 1'b0);
        run_pass(1'b0, 0, 1'b0);
        cur_etc = '{0, 0, 0, 0, 0};
        run_pass(1'b1, 0, 1'b0);
        cur_etc = '{15, 0, 0, 0, 0};
        run_pass(1'b1, 0, 1'b0);
        cur_etc = '{15, 15, 15, 15, 15};
        run_pass(1'b0, 0, 1'b0);
        cur_etc = '{1, 1, 1, 1, 1};
        run_pass(1'b0, 40, 1'b0);
        cur_etc = '{0, 2, 0, 3, 1};
        run_pass(1'b1, 20, 1'b1);

        // Reset in the middle of tap 2 aborts the pass without a done pulse.
        cur_etc = '{1, 1, 1, 1, 1};
        etcs = pack_etc();
        cfg_skip_zero = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 3; t++) begin
            #1;
            check("pre_reset_tap", current_tap, t);
            check("pre_reset_valid", tap_valid, 1);
            if (t < 2) begin
                @(posedge clk); #1;
            end
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_idle("mid_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("post_reset");

        for (int p = 0; p < 25; p++) begin
            for (int i = 0; i < NB; i++)
                cur_etc[i] = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(15, 1));
            run_pass(1'($urandom_range(1)), int'($urandom_range(50)), 1'($urandom_range(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
